// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: tracks the PC, precomputes the next fetch address,
// fetches one instruction per IF visit with a bounded wait, and holds the IR.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h00000000,
    parameter logic [31:0] INT_VECTOR    = 32'h00000004,
    parameter int          FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  current_state,
    input  logic        pc_write_enable,
    input  logic [2:0]  pc_source,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instruction,
    output logic [5:0]  opcode,
    output logic [5:0]  function_code,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  sa,
    output logic [15:0] immediate,
    output logic [31:0] pc,
    output logic        fetch_stall,
    output logic        fetch_error
);

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EXE  = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } fsm_state_t;

    localparam int CNT_W = (FETCH_TIMEOUT < 1) ? 1 : $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(FETCH_TIMEOUT);
    localparam logic [31:0] HALT_INSTR = 32'hFC000000;

    logic [31:0]      pc_reg;
    logic [31:0]      pc_next_reg;
    logic [31:0]      ir_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             fetch_error_reg;
    // Set once the current IF visit has been closed by an ack or a timeout
    // (and by reset), so a lingering IF state cannot fetch a second time.
    logic             visit_done_reg;

    logic        in_if;
    logic        timeout;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;

    assign in_if    = (current_state == ST_IF);
    assign imem_req = in_if && !visit_done_reg;
    assign timeout  = imem_req && !imem_ack && (wait_cnt_reg == TIMEOUT_CNT);

    assign imem_addr   = imem_req ? pc_next_reg : pc_reg;
    assign fetch_stall = imem_req && !imem_ack && (wait_cnt_reg != TIMEOUT_CNT);

    assign pc_plus4      = pc_reg + 32'd4;
    assign branch_target = pc_plus4 + {{14{ir_reg[15]}}, ir_reg[15:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], ir_reg[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (pc_source)
            3'd1:    next_pc = branch_target;
            3'd2:    next_pc = jump_target;
            3'd3:    next_pc = pc_reg;
            3'd4:    next_pc = INT_VECTOR;
            default: next_pc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg          <= RESET_PC;
            pc_next_reg     <= RESET_PC;
            ir_reg          <= 32'h00000000;
            wait_cnt_reg    <= '0;
            fetch_error_reg <= 1'b0;
            visit_done_reg  <= 1'b1;
        end else if (!in_if) begin
            pc_next_reg    <= pc_write_enable ? next_pc : pc_reg;
            wait_cnt_reg   <= '0;
            visit_done_reg <= 1'b0;
        end else if (imem_req && imem_ack) begin
            ir_reg         <= imem_rdata;
            pc_reg         <= pc_next_reg;
            wait_cnt_reg   <= '0;
            visit_done_reg <= 1'b1;
        end else if (timeout) begin
            ir_reg          <= HALT_INSTR;
            pc_reg          <= pc_next_reg;
            fetch_error_reg <= 1'b1;
            wait_cnt_reg    <= '0;
            visit_done_reg  <= 1'b1;
        end else if (imem_req) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    assign instruction   = ir_reg;
    assign pc            = pc_reg;
    assign fetch_error   = fetch_error_reg;
    assign opcode        = ir_reg[31:26];
    assign rs            = ir_reg[25:21];
    assign rt            = ir_reg[20:16];
    assign rd            = ir_reg[15:11];
    assign sa            = ir_reg[10:6];
    assign function_code = ir_reg[5:0];
    assign immediate     = ir_reg[15:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: stimulus queues expected fetches,
// a monitor pops and checks them whenever an IF visit closes.
module tb_instruction_fetch_unit;

    localparam logic [31:0] INT_VEC = 32'h40000020;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  current_state = 3'd4;
    logic        pc_write_enable = 1'b0;
    logic [2:0]  pc_source = 3'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ack = 1'b0;
    logic [31:0] instruction;
    logic [5:0]  opcode;
    logic [5:0]  function_code;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] immediate;
    logic [31:0] pc;
    logic        fetch_stall;
    logic        fetch_error;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ir;
        logic        err;
    } fetch_exp_t;

    fetch_exp_t exp_q[$];

    instruction_fetch_unit #(
        .RESET_PC(32'h00000000),
        .INT_VECTOR(INT_VEC),
        .FETCH_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .current_state(current_state),
        .pc_write_enable(pc_write_enable),
        .pc_source(pc_source),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ack(imem_ack),
        .instruction(instruction),
        .opcode(opcode),
        .function_code(function_code),
        .rs(rs),
        .rt(rt),
        .rd(rd),
        .sa(sa),
        .immediate(immediate),
        .pc(pc),
        .fetch_stall(fetch_stall),
        .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    // Monitor: an IF visit closes when a request is acked or times out.
    always begin
        @(negedge clk);
        if (imem_req && (imem_ack || !fetch_stall)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_fetch", 32'd1, 32'd0);
            end else begin
                fetch_exp_t e;
                e = exp_q.pop_front();
                chk("imem_addr", imem_addr, e.addr);
                @(posedge clk);
                #1;
                chk("ir", instruction, e.ir);
                chk("pc", pc, e.addr);
                chk("fetch_error", {31'd0, fetch_error}, {31'd0, e.err});
            end
        end
    end

    task automatic step(input logic [2:0] st, input logic [2:0] src, input logic we);
        current_state   = st;
        pc_source       = src;
        pc_write_enable = we;
        @(posedge clk);
        #1;
    endtask

    // One IF visit; delay<0 means the memory never acks.
    task automatic do_visit(input logic [31:0] addr, input logic [31:0] rdata,
                            input int delay, input int exp_stall,
                            input logic [31:0] exp_ir, input logic exp_err);
        fetch_exp_t e;
        int cyc;
        int stalls;
        bit done;
        e.addr = addr;
        e.ir   = exp_ir;
        e.err  = exp_err;
        exp_q.push_back(e);
        current_state = 3'd0;
        imem_rdata    = rdata;
        cyc = 0;
        stalls = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            imem_ack = (cyc == delay);
            @(negedge clk);
            if (fetch_stall) stalls++;
            if (imem_req && (imem_ack || !fetch_stall)) done = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        imem_ack = 1'b0;
        chk("visit_closed", {31'd0, done}, 32'd1);
        chk("stall_cycles", stalls, exp_stall);
        chk("visit_cycles", cyc, (delay < 0) ? exp_stall + 1 : delay + 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", instruction, 32'h0);
        chk("rst_err", {31'd0, fetch_error}, 32'd0);
        @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        step(3'd4, 3'd0, 1'b0);

        // addi $t0,$zero,5 with zero-wait memory
        do_visit(32'h0, 32'h20080005, 0, 0, 32'h20080005, 1'b0);
        chk("opcode", {26'd0, opcode}, 32'h08);
        chk("rt", {27'd0, rt}, 32'd8);
        chk("immediate", {16'd0, immediate}, 32'h0005);
        step(3'd1, 3'd0, 1'b1);
        step(3'd2, 3'd0, 1'b1);
        step(3'd3, 3'd0, 1'b1);
        step(3'd4, 3'd0, 1'b1);
        chk("opcode_stable", {26'd0, opcode}, 32'h08);

        // three wait states
        do_visit(32'h4, 32'h3C01ABCD, 3, 3, 32'h3C01ABCD, 1'b0);
        step(3'd1, 3'd0, 1'b1);

        // j 0x10
        do_visit(32'h8, 32'h08000004, 0, 0, 32'h08000004, 1'b0);
        step(3'd1, 3'd2, 1'b1);

        // beq with offset -2 words
        do_visit(32'h10, 32'h1000FFFE, 0, 0, 32'h1000FFFE, 1'b0);
        step(3'd2, 3'd1, 1'b1);
        step(3'd4, 3'd1, 1'b1);

        do_visit(32'h0C, 32'h08000009, 0, 0, 32'h08000009, 1'b0);
        step(3'd1, 3'd2, 1'b1);

        // ack in the same cycle as the timeout wins
        do_visit(32'h24, 32'h00000020, 15, 15, 32'h00000020, 1'b0);
        chk("function_code", {26'd0, function_code}, 32'h20);
        step(3'd1, 3'd0, 1'b0);

        do_visit(32'h24, 32'h00851020, 0, 0, 32'h00851020, 1'b0);
        chk("rd", {27'd0, rd}, 32'd2);
        step(3'd1, 3'd4, 1'b1);

        do_visit(INT_VEC, 32'h08000100, 0, 0, 32'h08000100, 1'b0);
        step(3'd1, 3'd2, 1'b1);

        // no ack at all -> halt injected, sticky error
        do_visit(32'h40000400, 32'hAAAAAAAA, -1, 15, 32'hFC000000, 1'b1);
        chk("halt_opcode", {26'd0, opcode}, 32'h3F);
        imem_ack   = 1'b1;
        imem_rdata = 32'h11111111;
        current_state = 3'd0;
        @(negedge clk);
        chk("late_ack_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        chk("late_ack_ir", instruction, 32'hFC000000);
        step(3'd2, 3'd3, 1'b1);

        do_visit(32'h40000400, 32'h12345678, 0, 0, 32'h12345678, 1'b1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h99999999;
        step(3'd0, 3'd0, 1'b1);
        imem_ack = 1'b0;
        chk("repeat_ack_ir", instruction, 32'h12345678);
        step(3'd1, 3'd7, 1'b1);

        do_visit(32'h40000404, 32'hCAFEF00D, 2, 2, 32'hCAFEF00D, 1'b1);
        step(3'd5, 3'd0, 1'b1);
        chk("err_held", {31'd0, fetch_error}, 32'd1);

        // reset in the middle of a waiting fetch
        step(3'd0, 3'd0, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("post_rst_req", {31'd0, imem_req}, 32'd0);
        chk("post_rst_stall", {31'd0, fetch_stall}, 32'd0);
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        chk("post_rst_ir", instruction, 32'h0);
        chk("post_rst_pc", pc, 32'h0);
        chk("post_rst_err", {31'd0, fetch_error}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
